// File: rtl/multicycle_ctrl.sv
// Multicycle RV control FSM: fetch/decode/exec/mem/wb sequencing,
// memory wait timeout, sticky fault and retired-instruction counter.
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic        pc_src,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        fault,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } st_t;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_LD  = 3'd2,
    C_ST  = 3'd3,
    C_BR  = 3'd4,
    C_BAD = 3'd5
  } cls_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

  st_t        cur;
  cls_t       cls;
  cls_t       dcls;
  logic [3:0] wcnt;
  logic [6:0] op;
  logic       unused_instr;

  assign op           = instruction[6:0];
  assign unused_instr = ^instruction[31:7];
  assign state        = cur;

  always_comb begin
    dcls = C_BAD;
    unique case (1'b1)
      op == 7'b0110011: dcls = C_R;
      op == 7'b0010011: dcls = C_I;
      op == 7'b0000011: dcls = C_LD;
      op == 7'b0100011: dcls = C_ST;
      op == 7'b1100011: dcls = C_BR;
      default:          dcls = C_BAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= FETCH;
      cls     <= C_R;
      wcnt    <= 4'd0;
      fault   <= 1'b0;
      retired <= 32'd0;
    end else begin
      case (cur)
        FETCH, MEM: begin
          if (mem_ready) begin
            wcnt <= 4'd0;
            if (cur == FETCH) begin
              cur <= DECODE;
            end else if (cls == C_LD) begin
              cur <= WB;
            end else begin
              cur     <= FETCH;
              retired <= retired + 32'd1;
            end
          end else if (wcnt == WAIT_LAST) begin
            wcnt  <= 4'd0;
            fault <= 1'b1;
            cur   <= HALT;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        DECODE: begin
          cls <= dcls;
          if (dcls == C_BAD) begin
            fault <= 1'b1;
            cur   <= HALT;
          end else begin
            cur <= EXEC;
          end
        end
        EXEC: begin
          case (cls)
            C_R, C_I:   cur <= WB;
            C_LD, C_ST: cur <= MEM;
            default: begin
              cur     <= FETCH;
              retired <= retired + 32'd1;
            end
          endcase
        end
        WB: begin
          cur     <= FETCH;
          retired <= retired + 32'd1;
        end
        default: cur <= HALT;
      endcase
    end
  end

  // Reset forces FETCH-like outputs but never lets ir/pc writes through.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    pc_src     = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    if (reset) begin
      mem_read = 1'b1;
    end else begin
      case (cur)
        FETCH: begin
          mem_read  = 1'b1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          alu_src_b = 2'b01;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          case (cls)
            C_R: alu_op = 2'b10;
            C_I, C_LD, C_ST: alu_src_b = 2'b10;
            C_BR: begin
              alu_op   = 2'b01;
              pc_src   = 1'b1;
              pc_write = zero;
            end
            default: alu_op = 2'b00;
          endcase
        end
        MEM: begin
          mem_read  = (cls == C_LD);
          mem_write = (cls == C_ST);
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls == C_LD);
        end
        default: reg_write = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of instruction runs
// plus hand sequences for fetch wait, illegal opcode, timeout, reset.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, mem_read, mem_write;
  logic        reg_write, mem_to_reg, alu_src_a, pc_src;
  logic [1:0]  alu_src_b, alu_op;
  logic [2:0]  state;
  logic        fault;
  logic [31:0] retired;

  int passed = 0;
  int total  = 0;

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        z;
    int          waits;
    int          len;
    logic [31:0] seq;
    logic        pcw;
    logic [1:0]  srcb;
    logic [1:0]  op;
    logic        m2r;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_mem_read", mem_read, 1);
    chk("rst_irpc", {ir_write, pc_write, mem_write, reg_write}, 0);
    @(posedge clk); #1;
    chk("rst_state", state, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retired", retired, 0);
    reset = 1'b0;
  endtask

  task automatic run(input vec_t v);
    logic [31:0] r0;
    logic [3:0]  s;
    int          memc;
    r0   = retired;
    memc = 0;
    instruction = v.instr;
    zero        = v.z;
    for (int i = 0; i < v.len; i++) begin
      s = v.seq[4*(v.len-1-i) +: 4];
      mem_ready = !(s == 4'd3 && memc < v.waits);
      if (s == 4'd3) memc++;
      @(negedge clk);
      chk("state", state, s);
      chk("reg_write", reg_write, s == 4'd4);
      if (s == 4'd0) chk("ir_write", ir_write, 1);
      if (s == 4'd2) begin
        chk("exec_pc_write", pc_write, v.pcw);
        chk("exec_src", {alu_src_a, alu_src_b, alu_op},
            {1'b1, v.srcb, v.op});
      end
      if (s == 4'd4) chk("mem_to_reg", mem_to_reg, v.m2r);
      @(posedge clk); #1;
    end
    chk("end_state", state, 0);
    chk("retired_inc", retired, r0 + 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'h00500093, 1'b0, 0, 4, 32'h0124,     1'b0, 2'b10, 2'b00, 1'b0};
    vt[1] = '{32'h002081B3, 1'b0, 0, 4, 32'h0124,     1'b0, 2'b00, 2'b10, 1'b0};
    vt[2] = '{32'h0080B103, 1'b0, 3, 8, 32'h01233334, 1'b0, 2'b10, 2'b00, 1'b1};
    vt[3] = '{32'h0080B103, 1'b0, 0, 5, 32'h01234,    1'b0, 2'b10, 2'b00, 1'b1};
    vt[4] = '{32'h0020B823, 1'b0, 0, 4, 32'h0123,     1'b0, 2'b10, 2'b00, 1'b0};
    vt[5] = '{32'h0020B823, 1'b0, 2, 6, 32'h012333,   1'b0, 2'b10, 2'b00, 1'b0};
    vt[6] = '{32'h00000063, 1'b1, 0, 3, 32'h012,      1'b1, 2'b00, 2'b01, 1'b0};
    vt[7] = '{32'h00000063, 1'b0, 0, 3, 32'h012,      1'b0, 2'b00, 2'b01, 1'b0};

    instruction = 32'h0;
    zero        = 1'b0;
    do_reset();

    for (int k = 0; k < 8; k++) run(vt[k]);
    chk("retired_total", retired, 8);

    // FETCH holds without mem_ready and suppresses ir/pc writes
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fetch_wait", {state, ir_write, pc_write}, 0);
      @(posedge clk); #1;
    end
    run(vt[0]);

    // unknown opcode
    instruction = 32'hFFFFFFFF;
    mem_ready   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bad_fault", fault, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_enables",
          {state, pc_write, ir_write, mem_read, mem_write, reg_write},
          {3'd5, 5'd0});
    end
    @(posedge clk); #1;
    do_reset();

    // store with memory never ready
    instruction = 32'h0020B823;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("mem_hold", {state, mem_write, fault}, {3'd3, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    chk("timeout_halt", {state, fault}, {3'd5, 1'b1});
    do_reset();

    // reset in the middle of MEM
    instruction = 32'h0020B823;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_mem", state, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out", {mem_read, mem_write, pc_write, ir_write}, 4'b1000);
    @(posedge clk); #1;
    chk("midrst_state", {state, fault}, 0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
